// File: rtl/instr_mem_loader.sv
// Instruction store with a valid/ready program-load port and a registered, stallable fetch port.
// Out-of-range fetches return a NOP and raise a sticky pc_fault until the next load or reset.
module instr_mem_loader #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned PC_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              loaded,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   current_pc,
  input  logic              stall,
  output logic [INSTR_W-1:0] instruction,
  output logic              instr_valid,
  output logic              pc_fault
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 fault_q, fault_d;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic                 wr_en;
  logic                 pc_in_range;
  logic [ADDR_W-1:0]    rd_addr;

  assign pc_in_range = (current_pc[PC_W-1:ADDR_W] == '0);
  assign rd_addr     = current_pc[ADDR_W-1:0];
  // A load_start in the same cycle as a word restarts the load and drops that word.
  assign wr_en       = (state_q == StLoad) && load_valid && !load_start;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (load_start) begin
      state_d = StLoad;
      count_d = '0;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_valid) begin
            count_d = count_q + (ADDR_W + 1)'(1);
            if (load_last || count_q == LastCount) state_d = StRun;
          end
        end
        StRun: begin
          if (!stall) begin
            if (fetch_req) begin
              valid_d = 1'b1;
              if (pc_in_range) begin
                instr_d = mem[rd_addr];
              end else begin
                instr_d = '0;
                fault_d = 1'b1;
              end
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= load_data;
  end

  assign load_ready  = (state_q == StLoad);
  assign loaded      = (state_q == StRun);
  assign load_count  = count_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_fault    = fault_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised and directed bench for instr_mem_loader against a behavioural model of the
// load/fetch rules, plus literal expectations from the directed scenarios.
module tb_instr_mem_loader;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 4096;
  localparam int ADDR_W  = 12;
  localparam int PC_W    = 32;

  logic clk = 1'b0, reset = 1'b0;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic fetch_req = 1'b0, stall = 1'b0;
  logic [INSTR_W-1:0] load_data = '0;
  logic [PC_W-1:0] current_pc = '0;
  logic load_ready, loaded, instr_valid, pc_fault;
  logic [ADDR_W:0] load_count;
  logic [INSTR_W-1:0] instruction;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_count(load_count), .loaded(loaded), .fetch_req(fetch_req),
    .current_pc(current_pc), .stall(stall), .instruction(instruction),
    .instr_valid(instr_valid), .pc_fault(pc_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = loading, 2 = running.
  int m_mode = 0, m_count = 0;
  logic [INSTR_W-1:0] m_mem [DEPTH];
  logic [INSTR_W-1:0] m_instr = '0;
  logic m_valid = 1'b0, m_fault = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_count = 0; m_instr = '0; m_valid = 1'b0; m_fault = 1'b0;
    end else if (load_start) begin
      m_mode = 1; m_count = 0; m_valid = 1'b0; m_fault = 1'b0;
    end else if (m_mode == 1) begin
      if (load_valid) begin
        m_mem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) m_mode = 2;
      end
    end else if (m_mode == 2 && !stall) begin
      if (fetch_req) begin
        m_valid = 1'b1;
        if (current_pc < DEPTH) m_instr = m_mem[current_pc];
        else begin m_instr = '0; m_fault = 1'b1; end
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("instruction", 32'(instruction), 32'(m_instr));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("pc_fault", 32'(pc_fault), 32'(m_fault));
    check("load_ready", 32'(load_ready), 32'(m_mode == 1));
    check("loaded", 32'(loaded), 32'(m_mode == 2));
    check("load_count", 32'(load_count), 32'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [INSTR_W-1:0] w [5];

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h0);
    reset = 1'b0;
    fetch_req = 1'b1;
    tick();
    check("idle_fetch_valid", 32'(instr_valid), 32'h0);
    fetch_req = 1'b0;

    // Basic three-word program, back-to-back fetches, stall hold.
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("ready_after_start", 32'(load_ready), 32'h1);
    load_valid = 1'b1;
    load_data = 9'h001; tick();
    load_data = 9'h0A5; tick();
    load_data = 9'h1FF; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("count3", 32'(load_count), 32'd3);
    check("loaded3", 32'(loaded), 32'h1);
    fetch_req = 1'b1;
    current_pc = 0; tick(); check("fetch0", 32'(instruction), 32'h001);
    current_pc = 1; tick(); check("fetch1", 32'(instruction), 32'h0A5);
    current_pc = 2; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", 32'(instruction), 32'h0A5);
    end
    stall = 1'b0; tick();
    check("fetch2", 32'(instruction), 32'h1FF);
    check("fetch2_valid", 32'(instr_valid), 32'h1);

    // Out-of-range fetch and sticky fault.
    current_pc = DEPTH; tick();
    check("oor_instr", 32'(instruction), 32'h0);
    check("oor_fault", 32'(pc_fault), 32'h1);
    current_pc = 0; tick();
    check("after_oor_instr", 32'(instruction), 32'h001);
    check("fault_sticky", 32'(pc_fault), 32'h1);

    // Restart with a coincident word, fetches ignored while loading.
    load_start = 1'b1; tick();
    check("fault_cleared", 32'(pc_fault), 32'h0);
    load_valid = 1'b1; load_data = 9'h055; tick();
    check("dropped_word", 32'(load_count), 32'h0);
    check("load_fetch_valid", 32'(instr_valid), 32'h0);
    load_start = 1'b0; fetch_req = 1'b0;

    // Fill the whole array without load_last.
    for (int i = 0; i < DEPTH; i++) begin
      load_data = INSTR_W'($urandom); tick();
    end
    load_valid = 1'b0;
    check("full_count", 32'(load_count), 32'd4096);
    check("full_ready", 32'(load_ready), 32'h0);
    check("full_loaded", 32'(loaded), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 63) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_last  = ($urandom_range(0, 7) == 0);
      load_data  = INSTR_W'($urandom);
      fetch_req  = $urandom_range(0, 3) != 0;
      stall      = ($urandom_range(0, 4) == 0);
      current_pc = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 100)
                                                  : $urandom_range(0, DEPTH - 1);
      tick();
    end
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    fetch_req = 1'b0; stall = 1'b0;
    tick();

    // Reset in the middle of a load, then a full reload read-back.
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data = INSTR_W'($urandom); tick();
    end
    load_valid = 1'b0;
    reset = 1'b1; tick();
    check("midrst_loaded", 32'(loaded), 32'h0);
    check("midrst_count", 32'(load_count), 32'h0);
    reset = 1'b0; fetch_req = 1'b1; current_pc = 0; tick();
    check("midrst_fetch_valid", 32'(instr_valid), 32'h0);
    fetch_req = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w[i] = INSTR_W'($urandom);
      load_data = w[i]; load_last = (i == 4); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("reload_count", 32'(load_count), 32'd5);
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      current_pc = i; tick();
      check("reload_read", 32'(instruction), 32'(w[i]));
    end
    fetch_req = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
